uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

- Round-robin controller that shares the single UART transmitter among `NUM_REQ` byte producers.
- Selects one pending requester, latches that requester's byte and line-control setting, and launches the transmitter with a start pulse.
- Holds the transmitter inputs stable until the frame-done pulse arrives, then enforces a programmable inter-frame gap before granting again.
- Sits between the producer blocks and the transmitter, on the transmitter's clock.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `DATA_W`, 8: byte width.
- `GAP_CYCLES`, 0: idle clocks inserted after each frame; 0 means no gap.
- `TIMEOUT_CYCLES`, 65535: watchdog limit in BUSY; only meaningful with `UART_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  bit i high means requester i has a byte pending.
- `req_data`  in  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- `req_lcr`  in  NUM_REQ*5  packed line-control words, 5 bits per requester.
- `ack`  out  NUM_REQ  one-cycle pulse on the granted requester's bit; signals that its byte has been latched.
- `tx_data`  out  DATA_W  byte to the transmitter data input.
- `tx_lcr`  out  5  line control to the transmitter.
- `tx_start`  out  1  one-cycle launch pulse to the transmitter.
- `tx_active`  in  1  transmitter busy flag; status only, does not affect the FSM.
- `tx_done`  in  1  transmitter frame-complete pulse.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current or last grant.
- `busy`  out  1  high in every state except IDLE.
- `timeout_flag`  out  1  one-cycle pulse when the watchdog aborts a frame.

## Operation
- FSM states: IDLE, START, BUSY, GAP.
- IDLE, with `req` != 0 at edge k:
  - Pick the first set bit scanning from `(last_grant+1) mod NUM_REQ` upward, wrapping past NUM_REQ-1 to 0.
  - Latch that requester's `req_data` and `req_lcr` into `tx_data` / `tx_lcr`.
  - Set `grant_id` and `last_grant` to the winner; go to START.
- START:
  - `tx_start`=1 and the winner's `ack` bit=1 for exactly this cycle.
  - Next state is BUSY.
- BUSY:
  - Wait for `tx_done`=1, then go to GAP if `GAP_CYCLES`>0, otherwise IDLE.
  - `tx_data` / `tx_lcr` stay frozen from latch until leaving BUSY.
- GAP: count `GAP_CYCLES` clocks, then go to IDLE.
- `tx_done` seen in any state other than BUSY is ignored.
- Requester handshake:
  - Hold `req`, data and lcr stable until `ack`.
  - In the cycle after `ack`, either drop `req` or present the next byte.
  - Deasserting `req` before grant withdraws the request with no side effects.
- A requester cannot be granted twice in a row while another requester is pending, which guarantees fairness.
- A single active requester is granted on every IDLE visit.

## Timing
- Reset values:
  - State IDLE.
  - `ack`, `tx_start`, `busy`, `timeout_flag` = 0.
  - `tx_data`, `tx_lcr`, `grant_id` = 0.
  - `last_grant` = NUM_REQ-1, so requester 0 has first priority.
- All outputs are registered.
- Latency: `req` sampled at edge k gives `tx_start`/`ack` high in cycle k+1 and `busy` high from k+1.
- `tx_done` sampled at edge d (GAP_CYCLES=0) gives IDLE in cycle d+1. A pending request is then latched at edge d+1, with the next `tx_start` in cycle d+2.
- With GAP_CYCLES=G>0, the next `tx_start` occurs no earlier than cycle d+G+2.
- Reset asserted mid-frame forces IDLE immediately and clears all outputs. The transmitter is reset by the same `rst`.

## Configuration
- Macro: `UART_ARB_TIMEOUT_EN`.
- With the macro defined:
  - A 16-bit counter clears on entering BUSY and increments every BUSY cycle.
  - On reaching `TIMEOUT_CYCLES` without `tx_done`, the FSM pulses `timeout_flag` for 1 cycle and goes to GAP (or IDLE if G=0).
  - The aborted requester is not re-acked.
- Without the macro: no counter, `timeout_flag` is tied to 0, and BUSY waits indefinitely for `tx_done`.

## Structure
- Shared package `uart_pkg`:
  - State enum typedef `arb_state_t`.
  - Constant `LCR_W`=5.
  - Default `DATA_W`=8.
- Sub-module `rr_picker`: purely combinational.
  - Inputs: `req` vector and `last_grant`.
  - Outputs: `winner` index and `any_req`.
  - The FSM, latching and counters live in `uart_tx_arbiter`.

## Test plan
- Reset, single request:
  - Stimulus: after reset, req=4'b0001, req_data[7:0]=8'hA5, lcr 5'b00011.
  - Expected: tx_start and ack[0] in the cycle after sampling, tx_data=8'hA5, tx_lcr=5'b00011.
  - tx_done pulse 10 cycles later returns the FSM to IDLE.
- All requesters pending:
  - Stimulus: req=4'b1111 held, every ack answered with a new byte, tx_done returned each frame.
  - Expected grant order: 0,1,2,3,0.
- Wrap-around:
  - Stimulus: last grant 3, req=4'b1001.
  - Expected: grant 0, then 3.
- Inter-frame gap:
  - Stimulus: GAP_CYCLES=3, two back-to-back requests.
  - Expected: tx_start spacing is exactly 5 cycles after tx_done.
- Reset mid-frame:
  - Stimulus: rst low during BUSY.
  - Expected: all outputs 0 immediately; a later tx_done pulse is ignored.
- Timeout (`UART_ARB_TIMEOUT_EN`):
  - Stimulus: TIMEOUT_CYCLES=20, tx_done never asserted.
  - Expected: timeout_flag pulses 20 cycles into BUSY, then the next pending requester is granted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    localparam int unsigned LCR_W      = 5;
    localparam int unsigned DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin selector: first pending requester after last_grant, wrapping.
module rr_picker #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        winner  = last_grant;
        any_req = 1'b0;
        idx     = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = IDX_W'((32'(last_grant) + i) % NUM_REQ);
            if (!any_req && req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional BUSY watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int unsigned NUM_REQ        = 4,
    parameter  int unsigned DATA_W         = DEF_DATA_W,
    parameter  int unsigned GAP_CYCLES     = 0,
    parameter  int unsigned TIMEOUT_CYCLES = 65535,
    localparam int unsigned IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*LCR_W-1:0]  req_lcr,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         tx_data,
    output logic [LCR_W-1:0]          tx_lcr,
    output logic                      tx_start,
    input  logic                      tx_active,
    input  logic                      tx_done,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy,
    output logic                      timeout_flag
);

    localparam int unsigned CNT_W = 16;

    arb_state_t         state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [IDX_W-1:0]   last_grant, last_next, grant_next;
    logic [IDX_W-1:0]   winner;
    logic               any_req;
    logic [DATA_W-1:0]  data_next;
    logic [LCR_W-1:0]   lcr_next;
    logic [NUM_REQ-1:0] ack_next;
    logic               start_next;
    logic               tout_next;

    // Transmitter busy flag is informational only.
    logic unused_tx_active;
    assign unused_tx_active = tx_active;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req        (req),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            last_grant   <= IDX_W'(NUM_REQ - 1);
            grant_id     <= '0;
            tx_data      <= '0;
            tx_lcr       <= '0;
            ack          <= '0;
            tx_start     <= 1'b0;
            busy         <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            last_grant   <= last_next;
            grant_id     <= grant_next;
            tx_data      <= data_next;
            tx_lcr       <= lcr_next;
            ack          <= ack_next;
            tx_start     <= start_next;
            busy         <= (state_next != IDLE);
            timeout_flag <= tout_next;
        end
    end

    // Next state plus next values of the registered outputs.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        last_next  = last_grant;
        grant_next = grant_id;
        data_next  = tx_data;
        lcr_next   = tx_lcr;
        ack_next   = '0;
        start_next = 1'b0;
        tout_next  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = START;
                    last_next  = winner;
                    grant_next = winner;
                    data_next  = req_data[32'(winner) * DATA_W +: DATA_W];
                    lcr_next   = req_lcr[32'(winner) * LCR_W +: LCR_W];
                    ack_next   = NUM_REQ'(1) << winner;
                    start_next = 1'b1;
                end
            end
            START: begin
                state_next = BUSY;
                cnt_next   = '0;
            end
            BUSY: begin
                if (tx_done) begin
                    state_next = (GAP_CYCLES != 0) ? GAP : IDLE;
                    cnt_next   = '0;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next = (GAP_CYCLES != 0) ? GAP : IDLE;
                    cnt_next   = '0;
                    tout_next  = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
`endif
            end
            GAP: begin
                if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed table, gap and reset sequences, random traffic vs. a transaction model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int unsigned N     = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned TO    = 20;
    localparam int unsigned NROW  = 12;
    localparam int unsigned NRAND = 2000;

    typedef struct {
        logic [N-1:0]     rq;
        logic [DW-1:0]    d;
        logic [LCR_W-1:0] l;
        int unsigned      w;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx_active = 1'b0;

    logic [N-1:0]       req = '0;
    logic [N*DW-1:0]    req_data = '0;
    logic [N*LCR_W-1:0] req_lcr = '0;
    logic               tx_done = 1'b0;
    logic [N-1:0]       ack;
    logic [DW-1:0]      tx_data;
    logic [LCR_W-1:0]   tx_lcr;
    logic               tx_start, busy, timeout_flag;
    logic [1:0]         grant_id;

    logic [N-1:0]       g_req = '0;
    logic [N*DW-1:0]    g_req_data = '0;
    logic [N*LCR_W-1:0] g_req_lcr = '0;
    logic               g_tx_done = 1'b0;
    logic [N-1:0]       g_ack;
    logic [DW-1:0]      g_tx_data;
    logic [LCR_W-1:0]   g_tx_lcr;
    logic               g_tx_start, g_busy, g_timeout_flag;
    logic [1:0]         g_grant_id;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]    cur_d [N];
    logic [LCR_W-1:0] cur_l [N];
    vec_t             tbl [NROW];

    int               e, free_at, busy_until, frame_start, done_at;
    int unsigned      m_last, w, exp_g;
    bit               in_frame, exp_start;
    logic [N-1:0]     exp_ack, s_req;
    logic             s_done;
    logic [DW-1:0]    exp_d;
    logic [LCR_W-1:0] exp_l;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TO)) dut0 (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_lcr(req_lcr),
        .ack(ack), .tx_data(tx_data), .tx_lcr(tx_lcr), .tx_start(tx_start),
        .tx_active(tx_active), .tx_done(tx_done), .grant_id(grant_id),
        .busy(busy), .timeout_flag(timeout_flag)
    );

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .GAP_CYCLES(3), .TIMEOUT_CYCLES(TO)) dut3 (
        .clk(clk), .rst(rst), .req(g_req), .req_data(g_req_data), .req_lcr(g_req_lcr),
        .ack(g_ack), .tx_data(g_tx_data), .tx_lcr(g_tx_lcr), .tx_start(g_tx_start),
        .tx_active(tx_active), .tx_done(g_tx_done), .grant_id(g_grant_id),
        .busy(g_busy), .timeout_flag(g_timeout_flag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load(input int i, input logic [DW-1:0] d, input logic [LCR_W-1:0] l);
        cur_d[i] = d;
        cur_l[i] = l;
        req_data[i*DW +: DW]      = d;
        req_lcr[i*LCR_W +: LCR_W] = l;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_start"}, 32'(tx_start), 0);
        check({tag, "_ack"}, 32'(ack), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_data"}, 32'(tx_data), 0);
        check({tag, "_lcr"}, 32'(tx_lcr), 0);
        check({tag, "_grant"}, 32'(grant_id), 0);
        check({tag, "_tout"}, 32'(timeout_flag), 0);
        check({tag, "_gbusy"}, 32'(g_busy), 0);
    endtask

    // Round-robin choice: rotate the request vector so the slot after last sits at bit 0, take its lowest set bit.
    function automatic int unsigned rr_pick(input logic [N-1:0] r, input int unsigned last);
        logic [2*N-1:0] dbl;
        logic [N-1:0]   rot;
        dbl = {r, r};
        rot = N'(dbl >> ((last + 1) % N));
        return (last + 1 + $clog2(32'(rot & (~rot + 1'b1)))) % N;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{4'b0001, 8'hA5, 5'b00011, 0};
        tbl[1]  = '{4'b1111, 8'h10, 5'h01, 1};
        tbl[2]  = '{4'b1111, 8'h20, 5'h02, 2};
        tbl[3]  = '{4'b1111, 8'h30, 5'h04, 3};
        tbl[4]  = '{4'b1111, 8'h40, 5'h05, 0};
        tbl[5]  = '{4'b1000, 8'h50, 5'h06, 3};
        tbl[6]  = '{4'b1001, 8'h60, 5'h07, 0};
        tbl[7]  = '{4'b1001, 8'h70, 5'h08, 3};
        tbl[8]  = '{4'b0100, 8'h80, 5'h09, 2};
        tbl[9]  = '{4'b0100, 8'h90, 5'h0A, 2};
        tbl[10] = '{4'b0110, 8'hA0, 5'h0B, 1};
        tbl[11] = '{4'b0011, 8'hB0, 5'h0C, 0};
        for (int i = 0; i < N; i++) load(i, '0, '0);

        repeat (3) tick();
        check_zero("in_reset");
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_zero("post_reset");

        // Directed grants, one full frame per row.
        for (int r = 0; r < NROW; r++) begin
            w = tbl[r].w;
            for (int i = 0; i < N; i++)
                if (tbl[r].rq[i] && !req[i]) load(i, tbl[r].d + DW'(i), tbl[r].l ^ LCR_W'(i));
            req = tbl[r].rq;
            tick();
            check("row_start", 32'(tx_start), 1);
            check("row_ack", 32'(ack), 32'(N'(1) << w));
            check("row_grant", 32'(grant_id), w);
            check("row_data", 32'(tx_data), 32'(cur_d[w]));
            check("row_lcr", 32'(tx_lcr), 32'(cur_l[w]));
            check("row_busy", 32'(busy), 1);
            req[w] = 1'b0;
            tick();
            check("row_start_pulse", 32'(tx_start), 0);
            check("row_ack_pulse", 32'(ack), 0);
            repeat ((r == 0) ? 8 : 2) tick();
            check("row_data_hold", 32'(tx_data), 32'(cur_d[w]));
            check("row_lcr_hold", 32'(tx_lcr), 32'(cur_l[w]));
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            check("row_idle", 32'(busy), 0);
        end

        // Reset in BUSY clears outputs at once; a stray tx_done afterwards does nothing.
        load(2, 8'h5A, 5'h15);
        req = 4'b0100;
        tick();
        check("mid_start", 32'(tx_start), 1);
        req = '0;
        repeat (2) tick();
        check("mid_busy", 32'(busy), 1);
        #2 rst = 1'b0;
        #1;
        check_zero("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("stray_done_busy", 32'(busy), 0);
        check("stray_done_start", 32'(tx_start), 0);
        load(2, 8'h66, 5'h02);
        load(3, 8'h77, 5'h03);
        req = 4'b1100;
        tick();
        check("post_mid_ack", 32'(ack), 32'(4'b0100));
        check("post_mid_data", 32'(tx_data), 32'(8'h66));
        req = '0;
        repeat (3) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("post_mid_idle", 32'(busy), 0);

        // Gap of 3: next start lands G+2 cycles after the done cycle; tx_done in GAP is ignored.
        g_req_data = {8'h00, 8'h00, 8'hC3, 8'h3C};
        g_req_lcr  = {5'd0, 5'd0, 5'h0E, 5'h07};
        g_req = 4'b0011;
        tick();
        check("gap_first_ack", 32'(g_ack), 32'(4'b0001));
        check("gap_first_data", 32'(g_tx_data), 32'(8'h3C));
        g_req[0] = 1'b0;
        repeat (3) tick();
        g_tx_done = 1'b1;
        tick();
        g_tx_done = 1'b0;
        check("gap_busy_after_done", 32'(g_busy), 1);
        for (int k = 1; k <= 6; k++) begin
            g_tx_done = (k == 2);
            tick();
            g_tx_done = 1'b0;
            check("gap_start_time", 32'(g_tx_start), 32'(k == 4));
            check("gap_busy", 32'(g_busy), 32'(k != 3));
            if (k == 4) begin
                check("gap_second_ack", 32'(g_ack), 32'(4'b0010));
                check("gap_second_lcr", 32'(g_tx_lcr), 32'(5'h0E));
                g_req[1] = 1'b0;
            end
        end

        // Random traffic against the transaction model.
        rst = 1'b0;
        req = '0;
        tx_done = 1'b0;
        for (int i = 0; i < N; i++) load(i, '0, '0);
        tick();
        @(negedge clk);
        rst = 1'b1;
        e = 0; free_at = 1; busy_until = 0; frame_start = 0; done_at = 0;
        in_frame = 1'b0; m_last = N - 1; exp_g = 0; exp_d = '0; exp_l = '0;
        for (int n = 0; n < NRAND; n++) begin
            s_req  = req;
            s_done = tx_done;
            tick();
            e++;
            exp_start = 1'b0;
            exp_ack   = '0;
            if (in_frame && s_done && e >= frame_start + 2) begin
                in_frame   = 1'b0;
                busy_until = e;
                free_at    = e + 1;
            end else if (!in_frame && e >= free_at && s_req != '0) begin
                w           = rr_pick(s_req, m_last);
                m_last      = w;
                in_frame    = 1'b1;
                frame_start = e;
                done_at     = e + int'($urandom_range(2, 12));
                exp_d       = cur_d[w];
                exp_l       = cur_l[w];
                exp_g       = w;
                exp_start   = 1'b1;
                exp_ack     = N'(1) << w;
            end
            check("rnd_start", 32'(tx_start), 32'(exp_start));
            check("rnd_ack", 32'(ack), 32'(exp_ack));
            check("rnd_busy", 32'(busy), 32'(in_frame || (e < busy_until)));
            check("rnd_grant", 32'(grant_id), exp_g);
            check("rnd_data", 32'(tx_data), 32'(exp_d));
            check("rnd_lcr", 32'(tx_lcr), 32'(exp_l));
            check("rnd_tout", 32'(timeout_flag), 0);
            for (int i = 0; i < N; i++) begin
                if (exp_ack[i]) begin
                    if ($urandom_range(0, 1) == 1) req[i] = 1'b0;
                    else load(i, DW'($urandom), LCR_W'($urandom));
                end else if (!req[i]) begin
                    if ($urandom_range(0, 5) == 0) begin
                        load(i, DW'($urandom), LCR_W'($urandom));
                        req[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 39) == 0) begin
                    req[i] = 1'b0;
                end
            end
            if (in_frame && (e + 1 >= frame_start + 2)) tx_done = (e + 1 == done_at);
            else tx_done = ($urandom_range(0, 7) == 0);
            tx_active = in_frame;
        end

`ifdef UART_ARB_TIMEOUT_EN
        // Watchdog abort after TO busy cycles, then the other pending requester wins.
        rst = 1'b0;
        req = '0;
        tx_done = 1'b0;
        tick();
        @(negedge clk);
        rst = 1'b1;
        load(0, 8'h11, 5'h01);
        load(1, 8'h22, 5'h02);
        req = 4'b0011;
        tick();
        check("to_start", 32'(tx_start), 1);
        req[0] = 1'b0;
        for (int j = 1; j <= TO + 1; j++) begin
            tick();
            check("to_flag", 32'(timeout_flag), 32'(j == TO + 1));
        end
        check("to_busy", 32'(busy), 0);
        tick();
        check("to_next_ack", 32'(ack), 32'(4'b0010));
        check("to_next_data", 32'(tx_data), 32'(8'h22));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
